// File: rtl/hazard3_ahb_pkg.sv
// hazard3_ahb_pkg: shared AHB-Lite constants, responder FSM state type,
// write-buffer record and byte-lane helpers used by the SRAM responder.
// No ports (package).
package hazard3_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_state_t;

  // One buffered store: lanes to write and the full data-phase word.
  typedef struct packed {
    logic        valid;
    logic [3:0]  mask;
    logic [31:0] data;
  } wbuf_t;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  // Take bytes of 'over' where mask is set, else bytes of 'base'.
  function automatic logic [31:0] merge_bytes(input logic [31:0] base, input logic [31:0] over,
                                              input logic [3:0] mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = mask[i] ? over[8*i +: 8] : base[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/hazard3_ahb_sram_1rw.sv
// hazard3_sram_1rw: single-port synchronous RAM, per-byte write enables,
// registered read data, contents not reset. A cycle with any wen bit set is
// a write; otherwise an enabled cycle is a read.
// Ports: clk, en (access enable), wen (byte write enables), addr (word
// address), wdata, rdata (valid the cycle after a read).
module hazard3_sram_1rw #(
  parameter int DEPTH  = 4096,
  parameter int W_DATA = 32
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [W_DATA/8-1:0]     wen,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W_DATA-1:0]       wdata,
  output logic [W_DATA-1:0]       rdata
);

  logic [W_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (|wen) begin
        for (int i = 0; i < W_DATA / 8; i++)
          if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/hazard3_ahb_sram.sv
// hazard3_ahb_sram: AHB-Lite responder in front of a single-port SRAM.
// Zero-wait reads and writes: reads go to the SRAM in the address phase,
// writes park in a one-entry buffer that drains on the next cycle without a
// read, and reads of the buffered word get the buffered bytes forwarded.
// Illegal accesses (bad size, misaligned, beyond DEPTH) get a two-cycle ERROR.
// Optional macro HAZARD3_AHB_SRAM_EXCL_EN adds a one-entry exclusive
// reservation monitor driving ahbls_hexokay; without it hexokay is 0 and
// hexcl is ignored.
// Ports: clk, rst_n (sync, active low), ahbls_* AHB-Lite responder port
// (haddr, hwrite, htrans, hsize, hready in; hready_resp, hresp out; hexcl in,
// hexokay out; hwdata in, hrdata out).
module hazard3_ahb_sram
  import hazard3_ahb_pkg::*;
#(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic              ahbls_hexcl,
  output logic              ahbls_hexokay,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata
);

  localparam int AW = $clog2(DEPTH);

  // Address-phase decode
  logic          aphase, a_illegal, a_legal, a_rd, a_wr, a_wr_ok, a_exok;
  logic [AW-1:0] a_word;

  assign aphase = ahbls_hready && ahbls_htrans[1];
  assign a_word = ahbls_haddr[AW+1:2];

  always_comb begin
    a_illegal = 1'b0;
    if (ahbls_hsize > HSIZE_WORD)                              a_illegal = 1'b1;
    if (ahbls_hsize == HSIZE_HALF && ahbls_haddr[0])           a_illegal = 1'b1;
    if (ahbls_hsize == HSIZE_WORD && |ahbls_haddr[1:0])        a_illegal = 1'b1;
    if ((ahbls_haddr >> (AW + 2)) != '0)                       a_illegal = 1'b1;
  end

  assign a_legal = aphase && !a_illegal;
  assign a_rd    = a_legal && !ahbls_hwrite;
  // A failed exclusive store is dropped here, so it never reaches the buffer.
  assign a_wr    = a_legal && ahbls_hwrite && a_wr_ok;

  logic unused_htrans0;
  assign unused_htrans0 = ahbls_htrans[0];

`ifdef HAZARD3_AHB_SRAM_EXCL_EN
  logic          res_valid;
  logic [AW-1:0] res_word;
  logic          res_hit;

  assign res_hit = res_valid && res_word == a_word;
  assign a_wr_ok = !ahbls_hexcl || res_hit;
  assign a_exok  = ahbls_hexcl && (!ahbls_hwrite || res_hit);

  // Any exclusive access consumes or (re)arms the reservation; a plain store
  // to the reserved word kills it. Errored accesses never reach here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_word  <= '0;
    end else if (a_legal && ahbls_hexcl) begin
      res_valid <= !ahbls_hwrite;
      res_word  <= a_word;
    end else if (a_legal && ahbls_hwrite && res_hit) begin
      res_valid <= 1'b0;
    end
  end
`else
  logic unused_hexcl;
  assign unused_hexcl = ahbls_hexcl;
  assign a_wr_ok = 1'b1;
  assign a_exok  = 1'b0;
`endif

  // Data-phase and buffer state
  ahb_state_t    state;
  logic          dp_rd, dp_wr;
  logic [AW-1:0] dp_word;
  logic [3:0]    dp_mask;
  wbuf_t         wb;
  logic [AW-1:0] wb_word;
  logic [3:0]    fwd_mask, fwd_mask_n;
  logic [31:0]   fwd_data, fwd_data_n;

  // SRAM port: reads win; the buffer drains on any cycle without a read.
  // Both are gated by reset so a pending store is dropped, not committed.
  logic              sram_en, commit;
  logic [3:0]        sram_wen;
  logic [AW-1:0]     sram_addr;
  logic [W_DATA-1:0] sram_rdata;

  assign commit    = wb.valid && !a_rd && rst_n;
  assign sram_en   = (a_rd && rst_n) || commit;
  assign sram_wen  = commit ? wb.mask : 4'h0;
  assign sram_addr = a_rd ? a_word : wb_word;

  hazard3_sram_1rw #(
    .DEPTH  (DEPTH),
    .W_DATA (W_DATA)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .wen   (sram_wen),
    .addr  (sram_addr),
    .wdata (wb.data),
    .rdata (sram_rdata)
  );

  // Forwarding sources for a read address phase: the parked store, and a
  // store whose data phase is this very cycle (its hwdata is not in the
  // buffer yet). The data-phase store is newer, so its bytes win.
  logic wb_hit, dp_hit;
  assign wb_hit = wb.valid && wb_word == a_word;
  assign dp_hit = dp_wr && dp_word == a_word;

  always_comb begin
    fwd_mask_n = (wb_hit ? wb.mask : 4'h0) | (dp_hit ? dp_mask : 4'h0);
    fwd_data_n = merge_bytes(wb.data, ahbls_hwdata, dp_hit ? dp_mask : 4'h0);
  end

  assign ahbls_hrdata = dp_rd ? merge_bytes(sram_rdata, fwd_data, fwd_mask) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      ahbls_hready_resp <= 1'b1;
      ahbls_hresp       <= 1'b0;
      ahbls_hexokay     <= 1'b0;
      dp_rd             <= 1'b0;
      dp_wr             <= 1'b0;
      wb.valid          <= 1'b0;
    end else begin
      case (state)
        ST_ERR1: begin
          state             <= ST_ERR2;
          ahbls_hready_resp <= 1'b1;
          ahbls_hresp       <= 1'b1;
        end
        default: begin
          // ERR2 completes the error response and accepts a new address
          // exactly like IDLE/DATA do.
          if (aphase && a_illegal) begin
            state             <= ST_ERR1;
            ahbls_hready_resp <= 1'b0;
            ahbls_hresp       <= 1'b1;
          end else begin
            state             <= aphase ? ST_DATA : ST_IDLE;
            ahbls_hready_resp <= 1'b1;
            ahbls_hresp       <= 1'b0;
          end
        end
      endcase

      dp_rd         <= a_rd;
      dp_wr         <= a_wr;
      ahbls_hexokay <= a_legal && a_exok;

      if (aphase) begin
        dp_word <= a_word;
        dp_mask <= byte_mask(ahbls_hsize, ahbls_haddr[1:0]);
      end

      if (a_rd) begin
        fwd_mask <= fwd_mask_n;
        fwd_data <= fwd_data_n;
      end

      // A write address phase always drains the buffer, so it is free again
      // by the time that write's data phase loads it.
      if (dp_wr) begin
        wb.valid <= 1'b1;
        wb.mask  <= dp_mask;
        wb.data  <= ahbls_hwdata;
        wb_word  <= dp_word;
      end else if (commit) begin
        wb.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hazard3_ahb_sram.sv
module tb_hazard3_ahb_sram;
  import hazard3_ahb_pkg::*;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;
  localparam int DEPTH  = 4096;

`ifdef HAZARD3_AHB_SRAM_EXCL_EN
  localparam bit EX = 1'b1;
`else
  localparam bit EX = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [W_ADDR-1:0] ahbls_haddr = '0;
  logic              ahbls_hwrite = 1'b0;
  logic [1:0]        ahbls_htrans = 2'b00;
  logic [2:0]        ahbls_hsize = 3'd0;
  logic              ahbls_hready;
  logic              ahbls_hready_resp;
  logic              ahbls_hresp;
  logic              ahbls_hexcl = 1'b0;
  logic              ahbls_hexokay;
  logic [W_DATA-1:0] ahbls_hwdata = '0;
  logic [W_DATA-1:0] ahbls_hrdata;

  // Single responder on the bus: bus HREADY is our own HREADYOUT.
  assign ahbls_hready = ahbls_hready_resp;

  always #5 clk = ~clk;

  hazard3_ahb_sram #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ahbls_haddr       (ahbls_haddr),
    .ahbls_hwrite      (ahbls_hwrite),
    .ahbls_htrans      (ahbls_htrans),
    .ahbls_hsize       (ahbls_hsize),
    .ahbls_hready      (ahbls_hready),
    .ahbls_hready_resp (ahbls_hready_resp),
    .ahbls_hresp       (ahbls_hresp),
    .ahbls_hexcl       (ahbls_hexcl),
    .ahbls_hexokay     (ahbls_hexokay),
    .ahbls_hwdata      (ahbls_hwdata),
    .ahbls_hrdata      (ahbls_hrdata)
  );

  typedef struct {
    bit          act;
    bit          wr;
    bit          excl;
    bit          err;
    bit          exok;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    logic [31:0] rd;
    int          id;
  } vec_t;

  vec_t seq[$];
  vec_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   vid = 0;

  function automatic void chk(string nm, int id, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %h want %h", nm, id, act, exp);
    end
  endfunction

  function automatic vec_t v_wr(logic [31:0] a, logic [2:0] s, logic [31:0] d,
                                bit x = 1'b0, bit exok = 1'b0, bit err = 1'b0);
    vec_t v;
    v.act = 1'b1; v.wr = 1'b1; v.excl = x; v.err = err; v.exok = exok;
    v.addr = a; v.size = s; v.wd = d; v.rd = '0; v.id = 0;
    return v;
  endfunction

  function automatic vec_t v_rd(logic [31:0] a, logic [2:0] s, logic [31:0] d,
                                bit x = 1'b0, bit exok = 1'b0, bit err = 1'b0);
    vec_t v;
    v.act = 1'b1; v.wr = 1'b0; v.excl = x; v.err = err; v.exok = exok;
    v.addr = a; v.size = s; v.wd = '0; v.rd = err ? 32'h0 : d; v.id = 0;
    return v;
  endfunction

  function automatic vec_t v_idle();
    vec_t v;
    v.act = 1'b0; v.wr = 1'b0; v.excl = 1'b0; v.err = 1'b0; v.exok = 1'b0;
    v.addr = '0; v.size = HSIZE_WORD; v.wd = '0; v.rd = '0; v.id = 0;
    return v;
  endfunction

  task automatic drive_idle();
    ahbls_htrans = HTRANS_IDLE;
    ahbls_hwrite = 1'b0;
    ahbls_hexcl  = 1'b0;
  endtask

  // Pipelined AHB master over seq[]: address phases pushed to the scoreboard
  // when driven, popped and compared when their data phase completes.
  task automatic run_seq();
    int          idx = 0;
    int          cyc = 0;
    int          dp_cyc = 0;
    bit          dp_act = 1'b0;
    bit          drove = 1'b0;
    logic [31:0] cur_wd = '0;
    logic [31:0] nxt_wd = '0;
    vec_t        e;
    while (idx < seq.size() || dp_act || drove) begin
      @(negedge clk);
      cyc++;
      if (drove) begin
        dp_act = 1'b1; dp_cyc = 0; cur_wd = nxt_wd; drove = 1'b0;
      end
      if (dp_act) begin
        e = sb[0];
        if (dp_cyc == 0) chk("hready", e.id, {31'b0, ahbls_hready_resp}, {31'b0, !e.err});
        if (ahbls_hready_resp) begin
          chk("hresp", e.id, {31'b0, ahbls_hresp}, {31'b0, e.err});
          chk("hrdata", e.id, ahbls_hrdata, e.rd);
          chk("hexokay", e.id, {31'b0, ahbls_hexokay}, {31'b0, e.exok});
          void'(sb.pop_front());
          dp_act = 1'b0;
        end else begin
          chk("err1_hresp", e.id, {31'b0, ahbls_hresp}, 32'h1);
          dp_cyc++;
          if (dp_cyc > 4) begin
            n_chk++; n_err++;
            $display("FAIL stall #%0d: hready_resp low for %0d cycles", e.id, dp_cyc);
            void'(sb.pop_front());
            dp_act = 1'b0;
          end
        end
      end
      ahbls_hwdata = cur_wd;
      if (ahbls_hready_resp && idx < seq.size()) begin
        e = seq[idx];
        e.id = vid++;
        ahbls_htrans = e.act ? HTRANS_NSEQ : HTRANS_IDLE;
        ahbls_haddr  = e.addr;
        ahbls_hwrite = e.wr;
        ahbls_hsize  = e.size;
        ahbls_hexcl  = e.excl;
        sb.push_back(e);
        nxt_wd = e.wd;
        drove = 1'b1;
        idx++;
      end else begin
        drive_idle();
      end
      if (cyc > 2000) begin
        n_chk++; n_err++;
        $display("FAIL timeout: sequence stuck after %0d cycles", cyc);
        break;
      end
    end
    drive_idle();
    seq.delete();
    sb.delete();
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hready", -1, {31'b0, ahbls_hready_resp}, 32'h1);
    chk("rst_hresp", -1, {31'b0, ahbls_hresp}, 32'h0);
    chk("rst_hexokay", -1, {31'b0, ahbls_hexokay}, 32'h0);
    chk("rst_hrdata", -1, ahbls_hrdata, 32'h0);
    rst_n = 1'b1;

    // Main table: forwarding, byte merge, errors, and recovery.
    seq = {
      v_wr(32'h10, HSIZE_WORD, 32'hDEADBEEF),
      v_rd(32'h10, HSIZE_WORD, 32'hDEADBEEF),
      v_wr(32'h20, HSIZE_WORD, 32'h11223344),
      v_idle(),
      v_wr(32'h21, HSIZE_BYTE, 32'h0000AA00),
      v_rd(32'h10, HSIZE_WORD, 32'hDEADBEEF),
      v_rd(32'h20, HSIZE_WORD, 32'h1122AA44),
      v_rd(32'h20, HSIZE_WORD, 32'h1122AA44),
      v_idle(),
      v_rd(32'h20, HSIZE_WORD, 32'h1122AA44),
      v_wr(32'h00, HSIZE_WORD, 32'hCAFEF00D),
      v_wr(32'h02, HSIZE_WORD, 32'hBADBAD00, 1'b0, 1'b0, 1'b1),
      v_rd(32'h00, HSIZE_WORD, 32'hCAFEF00D),
      v_rd(32'h4000, HSIZE_WORD, 32'h0, 1'b0, 1'b0, 1'b1),
      v_rd(32'h00, HSIZE_WORD, 32'hCAFEF00D),
      v_wr(32'h22, HSIZE_HALF, 32'h5A5A0000),
      v_rd(32'h20, HSIZE_WORD, 32'h5A5AAA44),
      v_rd(32'h01, HSIZE_HALF, 32'h0, 1'b0, 1'b0, 1'b1),
      v_rd(32'h04, 3'd3, 32'h0, 1'b0, 1'b0, 1'b1),
      v_wr(32'h12, HSIZE_HALF, 32'h12340000),
      v_rd(32'h10, HSIZE_WORD, 32'h1234BEEF)
    };
    run_seq();

    // Exclusive accesses; expectations depend on whether the monitor exists.
    seq = {
      v_wr(32'h40, HSIZE_WORD, 32'h0),
      v_rd(32'h40, HSIZE_WORD, 32'h0, 1'b1, EX),
      v_wr(32'h40, HSIZE_WORD, 32'h5, 1'b1, EX),
      v_rd(32'h40, HSIZE_WORD, 32'h5),
      v_wr(32'h40, HSIZE_WORD, 32'h6, 1'b1, 1'b0),
      v_rd(32'h40, HSIZE_WORD, EX ? 32'h5 : 32'h6),
      v_idle(),
      v_rd(32'h40, HSIZE_WORD, EX ? 32'h5 : 32'h6),
      v_wr(32'h44, HSIZE_WORD, 32'h7),
      v_rd(32'h44, HSIZE_WORD, 32'h7, 1'b1, EX),
      v_wr(32'h44, HSIZE_WORD, 32'h8),
      v_wr(32'h44, HSIZE_WORD, 32'h9, 1'b1, 1'b0),
      v_idle(),
      v_rd(32'h44, HSIZE_WORD, EX ? 32'h8 : 32'h9),
      v_wr(32'h48, HSIZE_WORD, 32'h11),
      v_rd(32'h48, HSIZE_WORD, 32'h11, 1'b1, EX),
      v_rd(32'h4000, HSIZE_WORD, 32'h0, 1'b1, 1'b0, 1'b1),
      v_wr(32'h48, HSIZE_WORD, 32'h22, 1'b1, EX),
      v_rd(32'h48, HSIZE_WORD, 32'h22)
    };
    run_seq();

    // Reset while a store is parked in the buffer: the store must be lost.
    seq = {v_wr(32'h80, HSIZE_WORD, 32'h12345678), v_idle()};
    run_seq();
    @(negedge clk);
    ahbls_htrans = HTRANS_NSEQ; ahbls_haddr = 32'h80; ahbls_hwrite = 1'b1; ahbls_hsize = HSIZE_WORD;
    @(negedge clk);
    ahbls_hwdata = 32'h87654321;
    ahbls_haddr = 32'h10; ahbls_hwrite = 1'b0;
    @(negedge clk);
    chk("pre_rst_rd", 900, ahbls_hrdata, 32'h1234BEEF);
    ahbls_hwdata = '0;
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_hready", 901, {31'b0, ahbls_hready_resp}, 32'h1);
    chk("rst2_hresp", 901, {31'b0, ahbls_hresp}, 32'h0);
    chk("rst2_hrdata", 901, ahbls_hrdata, 32'h0);
    chk("rst2_hexokay", 901, {31'b0, ahbls_hexokay}, 32'h0);
    rst_n = 1'b1;
    seq = {v_rd(32'h80, HSIZE_WORD, 32'h12345678), v_rd(32'h10, HSIZE_WORD, 32'h1234BEEF)};
    run_seq();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
